// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage elastic register pipeline with valid/ready handshake and collapsing bubbles.
// Optional feature macro DFF_PIPE_PARITY_EN carries a parity bit per stage and flags output mismatches.

module dff_pipe_chk #(
  parameter int DEPTH = 4,
  parameter int OCC_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DEPTH-1:0] v,
  input  logic [OCC_W-1:0] occ,
  input  logic             in_ready,
  input  logic             out_valid
);
  // The occupancy counter is an incremental copy of the valid flags and must never drift from them.
  a_occ_pop: assert property (@(posedge clk) disable iff (!rst_n) int'(occ) == $countones(v));
  a_occ_max: assert property (@(posedge clk) disable iff (!rst_n) int'(occ) <= DEPTH);
  a_frozen:  assert property (@(posedge clk) disable iff (!rst_n) !en |-> (!in_ready && !out_valid));
endmodule

module dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_par,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occ,
  output logic                       par_err
);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1'b1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] r_s;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             flow_s;
  logic             in_xfer_s;
  logic             out_xfer_s;

  // A stage may advance when any stage at or downstream of it is empty, or the consumer pops.
  always_comb begin
    logic chain_s;
    chain_s = out_ready;
    r_s     = {DEPTH{1'b0}};
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain_s = chain_s | ~v_q[k];
      r_s[k]  = chain_s;
    end
  end

  assign flow_s     = en & ~clr;
  assign in_ready   = rst_n & flow_s & r_s[0];
  assign out_valid  = v_q[DEPTH-1] & en;
  assign out_data   = d_q[DEPTH-1];
  assign occ        = occ_q;
  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = out_valid & out_ready;

  // Stage next-state: clear drops valids only, data registers keep their contents.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (clr) begin
      v_d = {DEPTH{1'b0}};
    end else if (en) begin
      if (r_s[0]) begin
        v_d[0] = in_valid;
        d_d[0] = in_data;
      end else begin
        v_d[0] = v_q[0];
        d_d[0] = d_q[0];
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (r_s[k]) begin
          v_d[k] = v_q[k-1];
          d_d[k] = d_q[k-1];
        end else begin
          v_d[k] = v_q[k];
          d_d[k] = d_q[k];
        end
      end
    end else begin
      v_d = v_q;
      d_d = d_q;
    end
  end

  // Occupancy tracks handshakes rather than recounting the valid flags every cycle.
  always_comb begin
    occ_d = occ_q;
    if (clr) begin
      occ_d = OCC_ZERO;
    end else if (in_xfer_s && !out_xfer_s && (occ_q != OCC_FULL)) begin
      occ_d = occ_q + OCC_ONE;
    end else if (!in_xfer_s && out_xfer_s && (occ_q != OCC_ZERO)) begin
      occ_d = occ_q - OCC_ONE;
    end else begin
      occ_d = occ_q;
    end
  end

  // Stage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= {DEPTH{1'b0}};
      occ_q <= OCC_ZERO;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= {WIDTH{1'b0}};
      end
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      occ_q <= occ_d;
    end
  end

`ifdef DFF_PIPE_PARITY_EN
  logic [DEPTH-1:0] p_q;
  logic [DEPTH-1:0] p_d;

  function automatic logic even_par(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  // Parity bits ride along with the data under exactly the same load conditions.
  always_comb begin
    p_d = p_q;
    if (clr) begin
      p_d = p_q;
    end else if (en) begin
      if (r_s[0]) begin
        p_d[0] = in_par;
      end else begin
        p_d[0] = p_q[0];
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (r_s[k]) begin
          p_d[k] = p_q[k-1];
        end else begin
          p_d[k] = p_q[k];
        end
      end
    end else begin
      p_d = p_q;
    end
  end

  // Parity storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= {DEPTH{1'b0}};
    end else begin
      p_q <= p_d;
    end
  end

  assign par_err = out_valid & (even_par(out_data) != p_q[DEPTH-1]);
`else
  logic unused_par_s;
  assign unused_par_s = in_par;
  assign par_err      = 1'b0;
`endif

  dff_pipe_chk #(
    .DEPTH (DEPTH),
    .OCC_W (OCC_W)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .v         (v_q),
    .occ       (occ_q),
    .in_ready  (in_ready),
    .out_valid (out_valid)
  );
endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: vector table, directed corner sequences, randomized run vs slot model.
module tb_dff_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH+1);
`ifdef DFF_PIPE_PARITY_EN
  localparam logic EXP_PE_BAD = 1'b1;
`else
  localparam logic EXP_PE_BAD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             en;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_par;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [OCC_W-1:0] occ;
  logic             par_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .en        (en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_par    (in_par),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occ       (occ),
    .par_err   (par_err)
  );

  // Reference: slots indexed by stage; per edge, a pop frees the last slot, then everything below
  // the highest free slot slides up one place and the input record enters slot 0.
  logic             m_v [DEPTH];
  logic [WIDTH-1:0] m_d [DEPTH];
  logic             m_p [DEPTH];

  // End-to-end ordering scoreboard for directed streaming sequences.
  logic [WIDTH-1:0] sb_q [$];
  bit sb_on = 1'b0;
  int acc_cnt, out_cnt, first_acc, first_out, last_out, sb_cyc;

  typedef struct packed {
    logic             en;
    logic             clr;
    logic             iv;
    logic [WIDTH-1:0] data;
    logic             ordy;
    logic             ov;
    logic [WIDTH-1:0] od;
    logic [OCC_W-1:0] occ;
    logic             ir;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int k = 0; k < DEPTH; k++) if (m_v[k]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = '0;
      m_p[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int h;
    if (clr) begin
      for (int k = 0; k < DEPTH; k++) m_v[k] = 1'b0;
    end else if (en) begin
      if (m_v[DEPTH-1] && out_ready) m_v[DEPTH-1] = 1'b0;
      h = -1;
      for (int k = 0; k < DEPTH; k++) if (!m_v[k]) h = k;
      if (h >= 0) begin
        for (int j = h; j > 0; j--) begin
          m_v[j] = m_v[j-1];
          m_d[j] = m_d[j-1];
          m_p[j] = m_p[j-1];
        end
        m_v[0] = in_valid;
        m_d[0] = in_data;
        m_p[0] = in_par;
      end
    end
  endtask

  task automatic drive(input logic e, input logic c, input logic iv, input logic [WIDTH-1:0] dd,
                       input logic ip, input logic ordy);
    @(negedge clk);
    en = e; clr = c; in_valid = iv; in_data = dd; in_par = ip; out_ready = ordy;
    #1;
  endtask

  // Compare all outputs against the model for the current cycle, then advance the model one edge.
  task automatic step(input string tag);
    logic exp_ov, exp_ir, exp_pe;
    exp_ov = en & m_v[DEPTH-1];
    exp_ir = rst_n & en & ~clr & ((m_count() < DEPTH) | out_ready);
`ifdef DFF_PIPE_PARITY_EN
    exp_pe = exp_ov & ((^m_d[DEPTH-1]) != m_p[DEPTH-1]);
`else
    exp_pe = 1'b0;
`endif
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
    chk({tag, ".out_data"},  32'(out_data),  32'(m_d[DEPTH-1]));
    chk({tag, ".occ"},       32'(occ),       32'(m_count()));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(exp_ir));
    chk({tag, ".par_err"},   32'(par_err),   32'(exp_pe));
    if (sb_on) begin
      if (in_valid && in_ready) begin
        sb_q.push_back(in_data);
        if (first_acc < 0) first_acc = sb_cyc;
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk({tag, ".sb_underflow"}, 32'd1, 32'd0);
        else chk({tag, ".sb_order"}, 32'(out_data), 32'(sb_q.pop_front()));
        if (first_out < 0) first_out = sb_cyc;
        last_out = sb_cyc;
        out_cnt++;
      end
      sb_cyc++;
    end
    model_edge();
  endtask

  task automatic sb_start();
    sb_q.delete();
    sb_on = 1'b1; acc_cnt = 0; out_cnt = 0; first_acc = -1; first_out = -1; last_out = -1; sb_cyc = 0;
  endtask

  initial begin
    int lat;
    bit found;
    logic [WIDTH-1:0] w;
    int bias;

    rst_n = 1'b0; clr = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0; in_par = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out_data",  32'(out_data),  32'd0);
    chk("reset.occ",       32'(occ),       32'd0);
    chk("reset.in_ready",  32'(in_ready),  32'd0);
    chk("reset.par_err",   32'(par_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    step("post_reset");

    // Bubble collapse, enable freeze, drain and clear, with hand-derived expectations.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 3'd2, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 3'd2, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 3'd2, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 8'h11, 3'd2, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 3'd2, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 3'd1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      w = tbl[i].data;
      drive(tbl[i].en, tbl[i].clr, tbl[i].iv, w, ^w, tbl[i].ordy);
      chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d.out_data", i),  32'(out_data),  32'(tbl[i].od));
      chk($sformatf("tbl%0d.occ", i),       32'(occ),       32'(tbl[i].occ));
      chk($sformatf("tbl%0d.in_ready", i),  32'(in_ready),  32'(tbl[i].ir));
      chk($sformatf("tbl%0d.par_err", i),   32'(par_err),   32'd0);
      model_edge();
    end

    // Asynchronous reset with three words in flight.
    for (int i = 0; i < 3; i++) begin
      w = 8'h51 + 8'(i);
      drive(1'b1, 1'b0, 1'b1, w, ^w, 1'b0);
      step("fill3");
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_rst.occ", 32'(occ), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.occ",       32'(occ),       32'd0);
    chk("mid_rst.out_data",  32'(out_data),  32'd0);
    chk("mid_rst.in_ready",  32'(in_ready),  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    step("rst_release");

    // Latency of one word through an empty pipe.
    drive(1'b1, 1'b0, 1'b1, 8'hA5, ^8'hA5, 1'b1);
    step("lat_in");
    lat = -1;
    for (int i = 1; i <= 2 * DEPTH; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      if (lat < 0 && out_valid && out_data == 8'hA5) lat = i;
      step("lat_wait");
      if (lat >= 0) break;
    end
    chk("latency", 32'(lat), 32'(DEPTH));

    // Full-rate streaming of 0x01..0x10.
    sb_start();
    for (int i = 0; i < 16; i++) begin
      w = 8'(i + 1);
      drive(1'b1, 1'b0, 1'b1, w, ^w, 1'b1);
      if (i >= DEPTH) chk("stream.occ_steady", 32'(occ), 32'(DEPTH));
      step("stream");
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      step("stream_drain");
    end
    chk("stream.count",     32'(out_cnt),             32'd16);
    chk("stream.first_lat", 32'(first_out - first_acc), 32'(DEPTH));
    chk("stream.no_gaps",   32'(last_out - first_out),  32'd15);

    // Backpressure: only DEPTH words enter, then release refills in the same cycle.
    sb_start();
    for (int i = 0; i < 10; i++) begin
      w = 8'h60 + 8'(i);
      drive(1'b1, 1'b0, 1'b1, w, ^w, 1'b0);
      step("bp_stall");
    end
    chk("bp.accepts", 32'(acc_cnt), 32'(DEPTH));
    for (int i = 0; i < 6; i++) begin
      w = 8'h70 + 8'(i);
      drive(1'b1, 1'b0, 1'b1, w, ^w, 1'b1);
      if (i == 0) chk("bp.refill_ready", 32'(in_ready), 32'd1);
      step("bp_release");
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      step("bp_drain");
    end
    chk("bp.all_out", 32'(out_cnt), 32'(DEPTH + 6));
    chk("bp.sb_empty", 32'(sb_q.size()), 32'd0);
    sb_on = 1'b0;

    // Enable low freezes mid-stream, then resume.
    for (int i = 0; i < 2; i++) begin
      w = 8'h81 + 8'(i);
      drive(1'b1, 1'b0, 1'b1, w, ^w, 1'b0);
      step("frz_fill");
    end
    for (int i = 0; i < 5; i++) begin
      w = 8'($urandom);
      drive(1'b0, 1'b0, 1'($urandom), w, ^w, 1'($urandom));
      step("frozen");
    end
    w = 8'h83;
    drive(1'b1, 1'b0, 1'b1, w, ^w, 1'b0);
    step("resume");

    // Clear with three words held, including a pending pop.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("clr.pre_occ", 32'(occ), 32'd3);
    step("clr_pre");
    drive(1'b1, 1'b1, 1'b1, 8'h99, ^8'h99, 1'b1);
    step("clr");
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("clr.occ",       32'(occ),       32'd0);
    chk("clr.out_valid", 32'(out_valid), 32'd0);
    step("clr_post");
    for (int i = 0; i < 2; i++) begin
      w = 8'h91 + 8'(i);
      drive(1'b1, 1'b0, 1'b1, w, ^w, 1'b0);
      step("clr2_fill");
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step("clr_en_low");
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("clr_en_low.occ", 32'(occ), 32'd0);
    step("clr_en_low_post");

    // Parity: a wrong parity bit is flagged only while its word is presented.
    for (int pass = 0; pass < 2; pass++) begin
      drive(1'b1, 1'b0, 1'b1, 8'h03, (pass == 0) ? 1'b1 : 1'b0, 1'b1);
      step("par_in");
      found = 1'b0;
      for (int i = 0; i < 2 * DEPTH; i++) begin
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        if (out_valid) begin
          found = 1'b1;
          chk(pass == 0 ? "par.bad_word" : "par.good_word", 32'(par_err),
              32'((pass == 0) ? EXP_PE_BAD : 1'b0));
        end
        step("par_wait");
        if (found) break;
      end
      chk("par.seen", 32'(found), 32'd1);
    end

    // Randomized traffic with alternating consumer pressure.
    for (int i = 0; i < 3000; i++) begin
      bias = ((i / 200) % 2 == 1) ? 85 : 30;
      w = 8'($urandom);
      drive(($urandom_range(0, 99) < 90) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
            w,
            ($urandom_range(0, 99) < 10) ? ~(^w) : ^w,
            ($urandom_range(0, 99) < bias) ? 1'b1 : 1'b0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised, elastic register pipeline: DEPTH stages of WIDTH-bit registers with per-stage valid flags, a global enable, and synchronous clear. It is the successor to the single-bit enable/clear flip-flop. It sits between a producer and a consumer on a valid/ready interface. Bubbles collapse, so an empty stage always accepts data even when the consumer stalls.

## Interface
Parameters:
- WIDTH, 8: data width in bits (≥1)
- DEPTH, 4: number of register stages (≥1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- clr  input  1  synchronous flush of all stages
- en  input  1  global enable; low freezes all state
- in_valid  input  1  producer offers in_data
- in_data  input  WIDTH  input word
- in_par  input  1  even parity of in_data, supplied by producer (used only with DFF_PIPE_PARITY_EN)
- in_ready  output  1  pipeline accepts a word this cycle
- out_valid  output  1  out_data is valid
- out_data  output  WIDTH  word in last stage
- out_ready  input  1  consumer accepts out_data
- occ  output  $clog2(DEPTH+1)  count of valid stages, 0..DEPTH
- par_err  output  1  parity mismatch on current output word

## Operation
- **Stage state:**
  - Stages 0..DEPTH-1 each hold v[k] and d[k].
  - Stage 0 is the input side; stage DEPTH-1 drives out_data.
- **Ready chain (combinational):**
  - r[DEPTH-1] = !v[DEPTH-1] | out_ready
  - r[k] = !v[k] | r[k+1]
  - in_ready = en & !clr & r[0]
- **Stage update,** when en & !clr & r[k]:
  - Stage 0 loads v ← in_valid and d ← in_data.
  - Stage k>0 loads v ← v[k-1] and d ← d[k-1].
  - Stages with r[k]=0 hold.
- **Transfers:**
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- **Outputs:**
  - out_valid = v[DEPTH-1] & en; a frozen pipe never presents a transfer.
  - out_data = d[DEPTH-1], always driven, including while invalid.
- **occ:**
  - Registered; equals the population count of v.
  - Updated +1 on an input-only transfer, −1 on an output-only transfer, unchanged when both or neither occur.
  - Never exceeds DEPTH or wraps below 0.
- **Clear:** clr=1 with en=1 or en=0 sets all v and occ to 0 on the next edge. d registers are left unchanged.
- **Priority:** rst_n > clr > en > normal flow.
- **Full pipe:** occ=DEPTH and out_ready=0 gives in_ready=0. With out_ready=1, in_ready=1 in the same cycle, and input and output transfers coexist.
- **Invalid input:** in_valid=0 with r[0]=1 loads a bubble (v[0]=0) into stage 0.

## Timing
- **Reset values** (rst_n low, asynchronous): all v=0, all d=0, occ=0.
  - Outputs: out_valid=0, out_data=0, in_ready=0 while rst_n low, par_err=0.
- **Latency:** a word accepted at edge t into an empty pipe gives out_valid=1 after edge t+DEPTH−1, i.e. DEPTH cycles from its input sample to its output sample.
- **Throughput:** one word per cycle while en=1 and out_ready=1.
- **Stall:**
  - With out_ready held low, the pipe fills until occ=DEPTH.
  - in_ready then drops combinationally in the same cycle.
- **Enable low:**
  - No state changes.
  - in_ready=0 and out_valid=0.
  - Resumes exactly where it stopped when en returns high.
- **Clear:**
  - in_ready=0 during the clr cycle, so no word is accepted.
  - The word on out_data is discarded even if out_ready=1.
- **Reset mid-stream:** all in-flight words are lost. Flow resumes on the first edge after rst_n deasserts.

## Configuration
- Macro: DFF_PIPE_PARITY_EN.
- **Defined:**
  - Each stage stores an extra parity bit p[k] alongside d[k], loaded from in_par and shifted with data.
  - par_err = out_valid & (^out_data != p[DEPTH-1]).
  - par_err is combinational and the word still flows normally.
- **Undefined:**
  - No parity storage.
  - in_par is ignored.
  - par_err is tied to 0.

## Test plan
- **Reset:** rst_n=0 mid-stream with occ=3 → out_valid=0, occ=0, out_data=0 immediately. After release, a 0xA5 at in_data emerges DEPTH cycles later.
- **Streaming:** DEPTH=4, sequence 0x01..0x10 with out_ready=1 → out_data matches in order, first valid 4 cycles after first accept, no gaps, occ steady at 4.
- **Backpressure:** out_ready=0 for 10 cycles while in_valid=1 → exactly 4 words accepted, in_ready=0 when occ=4. Releasing out_ready pops the words in order with the same-cycle refill.
- **Bubble collapse:** accept 0x11, idle 2 cycles, accept 0x22, hold out_ready=0 → both words become adjacent in stages 3 and 2, occ=2.
- **Enable/clear:**
  - en=0 for 5 cycles mid-stream → state frozen, out_valid=0.
  - clr=1 with occ=3 → occ=0 and out_valid=0 next cycle. clr asserted while en=0 also flushes.
- **Parity (macro on):** send 0x03 with in_par=1 (wrong) → par_err=1 exactly when that word has out_valid=1. Correct-parity words give par_err=0. With the macro off, par_err stays 0.
